option_writer: RTL and testbench
================================

OPTION_WRITER -- requirements
Module: option_writer

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- MAX_ROWS, 11, max board rows.
- MAX_COLS, 11, max board columns.
- MAX_NUM_OPTIONS, 84, max options per line.
- DEPTH, 1024, option BRAM words.

REQ-002 Ports, one per line (name, direction, width, meaning):
- clk, input, 1, clock.
- rst, input, 1, reset, synchronous, active-high.
- in_valid, input, 1, parser word strobe.
- in_header, input, 1, in_word is a line index, not an option.
- in_word, input, 16, parser output word.
- board_done, input, 1, parser end-of-board pulse.
- bram_we, output, 1, option BRAM write enable.
- bram_addr, output, clog2(DEPTH), write address.
- bram_din, output, 16, write data.
- rd_line, input, clog2(MAX_ROWS+MAX_COLS), line-table lookup index.
- rd_base, output, clog2(DEPTH), first BRAM address of rd_line.
- rd_count, output, clog2(MAX_NUM_OPTIONS)+1, option count of rd_line.
- total_options, output, clog2(DEPTH)+1, words written this board.
- board_ready, output, 1, one-cycle pulse: board stored.
- err, output, 1, sticky error.
- err_code, output, 2, 0 none, 1 bad index, 2 overflow, 3 protocol.

Function
REQ-003 The block SHALL accept one word per cycle with no backpressure; there is no ready signal.
REQ-004 The FSM SHALL have states IDLE, LINE, DONE and ERROR.
REQ-005 When in_valid && in_header && in_word < MAX_ROWS+MAX_COLS in IDLE, LINE or DONE, the block SHALL latch cur_line, set base[idx] to wr_ptr and count[idx] to 0, and go to LINE.
REQ-006 A header with in_word >= MAX_ROWS+MAX_COLS SHALL go to ERROR with err_code 1.
REQ-007 A header received in DONE SHALL first clear wr_ptr, total_options and every count entry (new board), then apply REQ-005 with base 0.
REQ-008 When in_valid && !in_header in LINE, the block SHALL register bram_we=1, bram_addr=wr_ptr and bram_din=in_word, then increment wr_ptr, count[cur_line] and total_options.
REQ-009 Write latency SHALL be exactly one cycle from in_valid to bram_we.
REQ-010 bram_we SHALL be 0 in every other cycle.
REQ-011 An option word arriving when wr_ptr == DEPTH, or when count[cur_line] == MAX_NUM_OPTIONS, SHALL NOT be written and SHALL go to ERROR with err_code 2.
REQ-012 An option word received in IDLE or DONE SHALL go to ERROR with err_code 3.
REQ-013 When board_done is high in IDLE or LINE, the block SHALL go to DONE and pulse board_ready in the next cycle.
REQ-014 If in_valid and board_done are high in the same cycle, the word SHALL be processed first; board_ready SHALL still fire once.
REQ-015 board_done in DONE or ERROR SHALL be ignored.
REQ-016 A repeated header for an already-seen line SHALL overwrite its base and count; earlier words stay in BRAM but are unreferenced.
REQ-017 rd_base and rd_count SHALL be registered with 1-cycle latency from rd_line.
REQ-018 An out-of-range rd_line SHALL return 0 on both outputs.
REQ-019 Same-cycle lookup and update of one line SHALL return the pre-update value.
REQ-020 ERROR SHALL be sticky until rst; all inputs except rd_line SHALL be ignored while in ERROR.

Reset
REQ-021 On rst the block SHALL enter IDLE and clear wr_ptr, cur_line and all base/count entries.
REQ-022 On rst every output SHALL be 0: bram_we, bram_addr, bram_din, rd_base, rd_count, total_options, board_ready, err, err_code.
REQ-023 rst asserted mid-line SHALL abort without any further BRAM write in the following cycle.

Configuration
REQ-024 With OPTION_WRITER_CHECKSUM_EN defined, the block SHALL add output checksum[15:0]: the XOR of all words written this board, cleared by rst and at new-board start, and valid when board_ready pulses.
REQ-025 Without OPTION_WRITER_CHECKSUM_EN, the checksum port and logic SHALL be absent; all other behaviour is identical.

Structure
REQ-026 A shared package, nonogram_pkg, SHALL hold the writer state enum, the err_code constants, and the MAX_ROWS, MAX_COLS, MAX_NUM_OPTIONS and DEPTH defaults.
REQ-027 The base/count storage SHALL be a sub-module, line_table, with a synchronous clear, one write port and a registered read port.

Verification
REQ-028 Header 0, options 0x0005 and 0x000A, board_done -> BRAM addr0=0x0005 and addr1=0x000A; rd_line 0 gives base 0, count 2; board_ready 1 pulse; total 2.
REQ-029 Headers 0 and 1 with 3 and 1 options -> rd_line 1 gives base 3, count 1.
REQ-030 Header value 22 (MAX_ROWS+MAX_COLS) -> err=1, err_code=1, no bram_we afterwards.
REQ-031 DEPTH=4, header 0 then 5 options -> 4 writes, then err_code=2 with the 5th word not written.
REQ-032 Option word before any header -> err_code=3.
REQ-033 After DONE, header 2 then option 0x0001 -> wr_ptr restarts at 0; rd_line 0 gives count 0; rd_line 2 gives base 0, count 1.

Source files
------------

// File: rtl/nonogram_pkg.sv
// ---------------------------------------------------------------------------
// nonogram_pkg
// Shared definitions for the nonogram option path:
//   - wr_state_e     : option writer FSM encoding (IDLE, LINE, DONE, ERROR)
//   - ERR_*          : err_code values reported by option_writer
//   - DEF_*          : default board / storage dimensions
//   - xor_fold       : running XOR used by the optional board checksum
// ---------------------------------------------------------------------------
package nonogram_pkg;

   typedef enum logic [1:0] {
      WR_IDLE  = 2'd0,
      WR_LINE  = 2'd1,
      WR_DONE  = 2'd2,
      WR_ERROR = 2'd3
   } wr_state_e;

   localparam logic [1:0] ERR_NONE     = 2'd0;
   localparam logic [1:0] ERR_INDEX    = 2'd1;
   localparam logic [1:0] ERR_OVERFLOW = 2'd2;
   localparam logic [1:0] ERR_PROTOCOL = 2'd3;

   localparam int DEF_MAX_ROWS        = 11;
   localparam int DEF_MAX_COLS        = 11;
   localparam int DEF_MAX_NUM_OPTIONS = 84;
   localparam int DEF_DEPTH           = 1024;

   function automatic logic [15:0] xor_fold(input logic [15:0] acc, input logic [15:0] word);
      return acc ^ word;
   endfunction

endpackage

// File: rtl/option_writer_line_table.sv
// ---------------------------------------------------------------------------
// line_table
// Per-line {base, count} storage for the option writer.
// Ports:
//   clk, rst       : clock, synchronous active-high reset (clears everything)
//   clr            : synchronous clear of all entries (new board); a write in
//                    the same cycle still lands on top of the cleared table
//   we, wr_idx,
//   wr_base,
//   wr_count       : single write port
//   rd_idx         : lookup index
//   rd_base,
//   rd_count       : registered lookup result (0 when rd_idx is out of range);
//                    a same-cycle write to rd_idx is not visible (old value)
// ---------------------------------------------------------------------------
module line_table import nonogram_pkg::*; #(
   parameter int NUM_LINES = 22,
   parameter int IW        = 5,
   parameter int BW        = 10,
   parameter int CW        = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          we,
   input  logic [IW-1:0] wr_idx,
   input  logic [BW-1:0] wr_base,
   input  logic [CW-1:0] wr_count,
   input  logic [IW-1:0] rd_idx,
   output logic [BW-1:0] rd_base,
   output logic [CW-1:0] rd_count
);

   logic [BW-1:0] base_r  [NUM_LINES];
   logic [CW-1:0] count_r [NUM_LINES];

   // Entry update: reset, then write, then board clear (write wins over clear)
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_LINES; i++) begin
         if (rst) begin
            base_r[i]  <= '0;
            count_r[i] <= '0;
         end else if (we && (int'(wr_idx) == i)) begin
            base_r[i]  <= wr_base;
            count_r[i] <= wr_count;
         end else if (clr) begin
            base_r[i]  <= '0;
            count_r[i] <= '0;
         end
      end
   end

   // Registered read port; samples the table before this cycle's write
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_base  <= '0;
         rd_count <= '0;
      end else if (int'(rd_idx) < NUM_LINES) begin
         rd_base  <= base_r[rd_idx];
         rd_count <= count_r[rd_idx];
      end else begin
         rd_base  <= '0;
         rd_count <= '0;
      end
   end

endmodule

// File: rtl/option_writer.sv
// ---------------------------------------------------------------------------
// option_writer
// Stores parser option words into the option BRAM and records, per board
// line, the first BRAM address and number of options. No backpressure: one
// word per cycle is always accepted.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   in_valid          : parser word strobe
//   in_header         : in_word is a line index rather than an option
//   in_word[15:0]     : parser word
//   board_done        : end-of-board pulse from parser
//   bram_we/addr/din  : option BRAM write port (one cycle after in_valid)
//   rd_line           : line-table lookup index
//   rd_base, rd_count : registered lookup result
//   total_options     : words written for the current board
//   board_ready       : one-cycle pulse after the board is stored
//   err, err_code     : sticky error and its cause (nonogram_pkg ERR_*)
// Optional build macro OPTION_WRITER_CHECKSUM_EN adds checksum[15:0], the XOR
// of all words written this board.
// ---------------------------------------------------------------------------
module option_writer import nonogram_pkg::*; #(
   parameter int MAX_ROWS        = DEF_MAX_ROWS,
   parameter int MAX_COLS        = DEF_MAX_COLS,
   parameter int MAX_NUM_OPTIONS = DEF_MAX_NUM_OPTIONS,
   parameter int DEPTH           = DEF_DEPTH
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   in_valid,
   input  logic                                   in_header,
   input  logic [15:0]                            in_word,
   input  logic                                   board_done,
   output logic                                   bram_we,
   output logic [$clog2(DEPTH)-1:0]               bram_addr,
   output logic [15:0]                            bram_din,
   input  logic [$clog2(MAX_ROWS+MAX_COLS)-1:0]   rd_line,
   output logic [$clog2(DEPTH)-1:0]               rd_base,
   output logic [$clog2(MAX_NUM_OPTIONS):0]       rd_count,
   output logic [$clog2(DEPTH):0]                 total_options,
   output logic                                   board_ready,
   output logic                                   err,
   output logic [1:0]                             err_code
`ifdef OPTION_WRITER_CHECKSUM_EN
   ,
   output logic [15:0]                            checksum
`endif
);

   localparam int NL = MAX_ROWS + MAX_COLS;
   localparam int LW = $clog2(NL);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam int CW = $clog2(MAX_NUM_OPTIONS) + 1;

   localparam logic [1:0] IDLE  = WR_IDLE;
   localparam logic [1:0] LINE  = WR_LINE;
   localparam logic [1:0] DONE  = WR_DONE;
   localparam logic [1:0] ERROR = WR_ERROR;

   logic [1:0]    state_r, state_nxt_s;
   logic [PW-1:0] wr_ptr_r;
   logic [LW-1:0] cur_line_r;
   logic [AW-1:0] cur_base_r;
   logic [CW-1:0] cur_count_r;
   logic          bram_we_r, board_ready_r, err_r;
   logic [AW-1:0] bram_addr_r;
   logic [15:0]   bram_din_r;
   logic [1:0]    err_code_r;

   logic          hdr_take_s, opt_write_s, new_board_s, done_take_s;
   logic          err_set_s;
   logic [1:0]    err_code_nxt_s;
   logic          tbl_we_s;
   logic [LW-1:0] tbl_idx_s;
   logic [AW-1:0] tbl_base_s;
   logic [CW-1:0] tbl_count_s;

   // Next-state and datapath decisions for the current input word
   always_comb begin
      state_nxt_s    = state_r;
      hdr_take_s     = 1'b0;
      opt_write_s    = 1'b0;
      new_board_s    = 1'b0;
      done_take_s    = 1'b0;
      err_set_s      = 1'b0;
      err_code_nxt_s = ERR_NONE;
      tbl_we_s       = 1'b0;
      tbl_idx_s      = cur_line_r;
      tbl_base_s     = cur_base_r;
      tbl_count_s    = cur_count_r;
      case (state_r)
         IDLE, LINE, DONE: begin
            if (in_valid && in_header) begin
               if (in_word < 16'(NL)) begin
                  hdr_take_s  = 1'b1;
                  new_board_s = (state_r == DONE);
                  state_nxt_s = LINE;
                  tbl_we_s    = 1'b1;
                  tbl_idx_s   = in_word[LW-1:0];
                  tbl_count_s = '0;
                  // A header after DONE starts a fresh board at address 0
                  if (new_board_s) begin
                     tbl_base_s = '0;
                  end else begin
                     tbl_base_s = wr_ptr_r[AW-1:0];
                  end
               end else begin
                  err_set_s      = 1'b1;
                  err_code_nxt_s = ERR_INDEX;
               end
            end else if (in_valid) begin
               if (state_r != LINE) begin
                  err_set_s      = 1'b1;
                  err_code_nxt_s = ERR_PROTOCOL;
               end else if ((wr_ptr_r == PW'(DEPTH)) ||
                            (cur_count_r == CW'(MAX_NUM_OPTIONS))) begin
                  err_set_s      = 1'b1;
                  err_code_nxt_s = ERR_OVERFLOW;
               end else begin
                  opt_write_s = 1'b1;
                  tbl_we_s    = 1'b1;
                  tbl_count_s = cur_count_r + CW'(1);
               end
            end else begin
               state_nxt_s = state_r;
            end
            // The word (if any) is handled first; board_done only counts
            // when entered from IDLE/LINE and the word did not fault
            if (err_set_s) begin
               state_nxt_s = ERROR;
            end else if (board_done && (state_r != DONE)) begin
               done_take_s = 1'b1;
               state_nxt_s = DONE;
            end else begin
               done_take_s = 1'b0;
            end
         end
         ERROR: begin
            state_nxt_s = ERROR;
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // FSM, write pointer, current-line shadow and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r       <= IDLE;
         wr_ptr_r      <= '0;
         cur_line_r    <= '0;
         cur_base_r    <= '0;
         cur_count_r   <= '0;
         bram_we_r     <= 1'b0;
         bram_addr_r   <= '0;
         bram_din_r    <= 16'd0;
         board_ready_r <= 1'b0;
         err_r         <= 1'b0;
         err_code_r    <= ERR_NONE;
      end else begin
         state_r       <= state_nxt_s;
         bram_we_r     <= opt_write_s;
         board_ready_r <= done_take_s;
         if (opt_write_s) begin
            bram_addr_r <= wr_ptr_r[AW-1:0];
            bram_din_r  <= in_word;
            wr_ptr_r    <= wr_ptr_r + PW'(1);
            cur_count_r <= tbl_count_s;
         end else if (new_board_s) begin
            wr_ptr_r    <= '0;
         end
         if (hdr_take_s) begin
            cur_line_r  <= in_word[LW-1:0];
            cur_base_r  <= tbl_base_s;
            cur_count_r <= '0;
         end
         if (err_set_s) begin
            err_r      <= 1'b1;
            err_code_r <= err_code_nxt_s;
         end
      end
   end

`ifdef OPTION_WRITER_CHECKSUM_EN
   logic [15:0] checksum_r;

   // Running XOR of written words, restarted with each new board
   always_ff @(posedge clk) begin
      if (rst || new_board_s) begin
         checksum_r <= 16'd0;
      end else if (opt_write_s) begin
         checksum_r <= xor_fold(checksum_r, in_word);
      end
   end

   assign checksum = checksum_r;
`endif

   line_table #(
      .NUM_LINES (NL),
      .IW        (LW),
      .BW        (AW),
      .CW        (CW)
   ) u_line_table (
      .clk      (clk),
      .rst      (rst),
      .clr      (new_board_s),
      .we       (tbl_we_s),
      .wr_idx   (tbl_idx_s),
      .wr_base  (tbl_base_s),
      .wr_count (tbl_count_s),
      .rd_idx   (rd_line),
      .rd_base  (rd_base),
      .rd_count (rd_count)
   );

   // total_options tracks the write pointer: both restart with each board
   assign total_options = wr_ptr_r;
   assign bram_we       = bram_we_r;
   assign bram_addr     = bram_addr_r;
   assign bram_din      = bram_din_r;
   assign board_ready   = board_ready_r;
   assign err           = err_r;
   assign err_code      = err_code_r;

endmodule

// File: tb/tb_option_writer.sv
// ---------------------------------------------------------------------------
// tb_option_writer
// Scoreboarded bench: dut_a uses default parameters, dut_b uses DEPTH=4 for
// the storage-overflow case. Expected BRAM writes are queued when an option
// is driven and popped when the DUT raises bram_we.
// ---------------------------------------------------------------------------
module tb_option_writer;

   logic        clk = 1'b0;
   logic        rst;

   logic        in_valid_a, in_header_a, board_done_a;
   logic [15:0] in_word_a;
   logic [4:0]  rd_line_a;
   logic        bram_we_a, board_ready_a, err_a;
   logic [9:0]  bram_addr_a, rd_base_a;
   logic [15:0] bram_din_a;
   logic [7:0]  rd_count_a;
   logic [10:0] total_a;
   logic [1:0]  err_code_a;

   logic        in_valid_b, in_header_b, board_done_b;
   logic [15:0] in_word_b;
   logic [4:0]  rd_line_b;
   logic        bram_we_b, board_ready_b, err_b;
   logic [1:0]  bram_addr_b, rd_base_b;
   logic [15:0] bram_din_b;
   logic [7:0]  rd_count_b;
   logic [2:0]  total_b;
   logic [1:0]  err_code_b;

`ifdef OPTION_WRITER_CHECKSUM_EN
   logic [15:0] checksum_a, checksum_b;
`endif

   logic [31:0] qa[$];
   logic [31:0] qb[$];
   int          n_cmp = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   option_writer dut_a (
      .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_header(in_header_a),
      .in_word(in_word_a), .board_done(board_done_a), .bram_we(bram_we_a),
      .bram_addr(bram_addr_a), .bram_din(bram_din_a), .rd_line(rd_line_a),
      .rd_base(rd_base_a), .rd_count(rd_count_a), .total_options(total_a),
      .board_ready(board_ready_a), .err(err_a), .err_code(err_code_a)
`ifdef OPTION_WRITER_CHECKSUM_EN
      , .checksum(checksum_a)
`endif
   );

   option_writer #(.DEPTH(4)) dut_b (
      .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_header(in_header_b),
      .in_word(in_word_b), .board_done(board_done_b), .bram_we(bram_we_b),
      .bram_addr(bram_addr_b), .bram_din(bram_din_b), .rd_line(rd_line_b),
      .rd_base(rd_base_b), .rd_count(rd_count_b), .total_options(total_b),
      .board_ready(board_ready_b), .err(err_b), .err_code(err_code_b)
`ifdef OPTION_WRITER_CHECKSUM_EN
      , .checksum(checksum_b)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit sel, input logic v, input logic h,
                        input logic [15:0] w, input logic d);
      if (!sel) begin
         in_valid_a = v; in_header_a = h; in_word_a = w; board_done_a = d;
      end else begin
         in_valid_b = v; in_header_b = h; in_word_b = w; board_done_b = d;
      end
   endtask

   task automatic send_hdr(input bit sel, input int idx);
      drive(sel, 1'b1, 1'b1, 16'(idx), 1'b0);
      step();
      drive(sel, 1'b0, 1'b0, 16'd0, 1'b0);
   endtask

   // Drive one option word; the write must be visible right after the edge
   task automatic send_opt(input bit sel, input logic [15:0] w, input int addr,
                           input bit expect_wr, input bit with_done);
      if (expect_wr) begin
         if (!sel) qa.push_back({16'(addr), w});
         else      qb.push_back({16'(addr), w});
      end
      drive(sel, 1'b1, 1'b0, w, with_done);
      step();
      if (!sel) check("bram_we_a", 32'(bram_we_a), 32'(expect_wr));
      else      check("bram_we_b", 32'(bram_we_b), 32'(expect_wr));
      drive(sel, 1'b0, 1'b0, 16'd0, 1'b0);
   endtask

   task automatic pulse_done(input logic exp_ready);
      drive(1'b0, 1'b0, 1'b0, 16'd0, 1'b1);
      step();
      check("board_ready", 32'(board_ready_a), 32'(exp_ready));
      drive(1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
      step();
      check("board_ready_low", 32'(board_ready_a), 32'd0);
   endtask

   task automatic lookup(input int line, input int exp_base, input int exp_cnt);
      rd_line_a = 5'(line);
      step();
      check("rd_base", 32'(rd_base_a), 32'(exp_base));
      check("rd_count", 32'(rd_count_a), 32'(exp_cnt));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   // Scoreboard consumers: every bram_we must match the oldest expectation
   always @(negedge clk) begin : mon_a
      logic [31:0] e;
      if (bram_we_a === 1'b1) begin
         if (qa.size() == 0) begin
            check("unexpected_write_a", 32'd1, 32'd0);
         end else begin
            e = qa.pop_front();
            check("bram_a", {16'(bram_addr_a), bram_din_a}, e);
         end
      end
   end

   always @(negedge clk) begin : mon_b
      logic [31:0] e;
      if (bram_we_b === 1'b1) begin
         if (qb.size() == 0) begin
            check("unexpected_write_b", 32'd1, 32'd0);
         end else begin
            e = qb.pop_front();
            check("bram_b", {16'(bram_addr_b), bram_din_b}, e);
         end
      end
   end

   initial begin
      rd_line_a = 5'd0;
      rd_line_b = 5'd0;
      drive(1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 16'd0, 1'b0);
      rst = 1'b1;
      step();
      step();
      check("rst_we", 32'(bram_we_a), 32'd0);
      check("rst_addr", 32'(bram_addr_a), 32'd0);
      check("rst_din", 32'(bram_din_a), 32'd0);
      check("rst_rd_base", 32'(rd_base_a), 32'd0);
      check("rst_rd_count", 32'(rd_count_a), 32'd0);
      check("rst_total", 32'(total_a), 32'd0);
      check("rst_ready", 32'(board_ready_a), 32'd0);
      check("rst_err", {30'd0, err_code_a} | 32'(err_a), 32'd0);
      rst = 1'b0;

      // Basic board: one line, two options
      send_hdr(1'b0, 0);
      send_opt(1'b0, 16'h0005, 0, 1'b1, 1'b0);
      send_opt(1'b0, 16'h000A, 1, 1'b1, 1'b0);
      pulse_done(1'b1);
      check("total_basic", 32'(total_a), 32'd2);
      lookup(0, 0, 2);
      pulse_done(1'b0);              // board_done while already DONE

      // New board after DONE restarts storage and clears counts
      send_hdr(1'b0, 2);
      send_opt(1'b0, 16'h0001, 0, 1'b1, 1'b0);
      check("total_newboard", 32'(total_a), 32'd1);
      lookup(0, 0, 0);
      lookup(2, 0, 1);
      pulse_done(1'b1);

      // Two lines; last word arrives together with board_done
      send_hdr(1'b0, 0);
      send_opt(1'b0, 16'h0100, 0, 1'b1, 1'b0);
      send_opt(1'b0, 16'h0101, 1, 1'b1, 1'b0);
      send_opt(1'b0, 16'h0102, 2, 1'b1, 1'b0);
      send_hdr(1'b0, 1);
      send_opt(1'b0, 16'h0200, 3, 1'b1, 1'b1);
      check("ready_with_word", 32'(board_ready_a), 32'd1);
      step();
      check("ready_once", 32'(board_ready_a), 32'd0);
      lookup(1, 3, 1);
      lookup(0, 0, 3);
      check("total_two_lines", 32'(total_a), 32'd4);

      // Repeated header re-bases the line; same-cycle lookup sees old value
      send_hdr(1'b0, 5);
      send_opt(1'b0, 16'h0011, 0, 1'b1, 1'b0);
      send_hdr(1'b0, 5);
      send_opt(1'b0, 16'h0022, 1, 1'b1, 1'b0);
      lookup(5, 1, 1);
      rd_line_a = 5'd5;
      send_opt(1'b0, 16'h0033, 2, 1'b1, 1'b0);
      check("rd_pre_update", 32'(rd_count_a), 32'd1);
      step();
      check("rd_post_update", 32'(rd_count_a), 32'd2);
      lookup(22, 0, 0);
      lookup(31, 0, 0);

      // Reset mid-line: the concurrent word must not be written
      drive(1'b0, 1'b1, 1'b0, 16'h0044, 1'b0);
      rst = 1'b1;
      step();
      check("rst_midline_we", 32'(bram_we_a), 32'd0);
      check("rst_midline_total", 32'(total_a), 32'd0);
      drive(1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
      step();
      check("rst_midline_we2", 32'(bram_we_a), 32'd0);
      rst = 1'b0;

      // Option before any header
      send_opt(1'b0, 16'h0055, 0, 1'b0, 1'b0);
      check("proto_err", 32'(err_a), 32'd1);
      check("proto_code", 32'(err_code_a), 32'd3);
      send_hdr(1'b0, 3);
      send_opt(1'b0, 16'h0066, 0, 1'b0, 1'b0);
      check("proto_sticky", 32'(err_code_a), 32'd3);
      pulse_done(1'b0);

      // Header index out of range
      do_reset();
      send_hdr(1'b0, 22);
      check("index_err", 32'(err_a), 32'd1);
      check("index_code", 32'(err_code_a), 32'd1);
      send_opt(1'b0, 16'h0077, 0, 1'b0, 1'b0);
      check("index_sticky", 32'(err_code_a), 32'd1);

      // Storage overflow on the DEPTH=4 instance
      do_reset();
      send_hdr(1'b1, 0);
      for (int i = 0; i < 4; i++) begin
         send_opt(1'b1, 16'(16'h0A00 + i), i, 1'b1, 1'b0);
      end
      send_opt(1'b1, 16'h0BAD, 0, 1'b0, 1'b0);
      check("ovf_err", 32'(err_b), 32'd1);
      check("ovf_code", 32'(err_code_b), 32'd2);
      check("ovf_total", 32'(total_b), 32'd4);

      step();
      check("queue_a_empty", 32'(qa.size()), 32'd0);
      check("queue_b_empty", 32'(qb.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
